// File: rtl/db9_joy_pkg.sv
// Shared constants and types for the DB9 joystick reader: joy_o bit layout,
// pin layout and the 8-step select/sample sequence.
package db9_joy_pkg;

   // Published word layout {M,X,Y,Z,S,A,C,B,R,L,D,U}
   localparam int JOY_U = 0;
   localparam int JOY_D = 1;
   localparam int JOY_L = 2;
   localparam int JOY_R = 3;
   localparam int JOY_B = 4;
   localparam int JOY_C = 5;
   localparam int JOY_A = 6;
   localparam int JOY_S = 7;
   localparam int JOY_Z = 8;
   localparam int JOY_Y = 9;
   localparam int JOY_X = 10;
   localparam int JOY_M = 11;

   // Raw pin layout {p9,p6,right,left,down,up}
   localparam int PIN_U  = 0;
   localparam int PIN_D  = 1;
   localparam int PIN_L  = 2;
   localparam int PIN_R  = 3;
   localparam int PIN_P6 = 4;
   localparam int PIN_P9 = 5;

   localparam int SEQ_STEPS = 8;

   localparam logic [2:0] STEP_SEL0       = 3'd0;
   localparam logic [2:0] STEP_SEL1       = 3'd1;
   localparam logic [2:0] STEP_SAMPLE_HI  = 3'd2;
   localparam logic [2:0] STEP_SAMPLE_LO  = 3'd3;
   localparam logic [2:0] STEP_SEL4       = 3'd4;
   localparam logic [2:0] STEP_DETECT6    = 3'd5;
   localparam logic [2:0] STEP_SAMPLE_EXT = 3'd6;
   localparam logic [2:0] STEP_PUB        = 3'd7;

   typedef logic [11:0] joy_word_t;

   typedef struct packed {
      logic      six;
      logic      md;
      joy_word_t word;
   } joy_status_t;

   // Select level left behind by each sequence step: even steps pull low.
   function automatic logic seq_select(input logic [2:0] step);
      return step[0];
   endfunction

endpackage

// File: rtl/db9_joy_reader_if.sv
// Pad-side and publish-side signals of the DB9 joystick reader, grouped so
// the top level and its user share one bundle.
interface db9_joy_reader_if #(
   parameter int NUM_PORTS = 2
);
   logic [NUM_PORTS*6-1:0]  joy_pins_i;
   logic                    select_o;
   logic [NUM_PORTS*12-1:0] joy_o;
   logic [NUM_PORTS-1:0]    six_button_o;
   logic [NUM_PORTS-1:0]    md_pad_o;
   logic                    frame_done_o;

   modport master (
      output joy_pins_i,
      input  select_o, joy_o, six_button_o, md_pad_o, frame_done_o
   );

   modport slave (
      input  joy_pins_i,
      output select_o, joy_o, six_button_o, md_pad_o, frame_done_o
   );
endinterface

// File: rtl/db9_joy_port.sv
// One DB9 port: pin synchronizer, active-low shadow word, pad-type detection
// and atomic publish. DB9_JOY_DEBOUNCE_EN adds 2-frame agreement on publish.
module db9_joy_port
   import db9_joy_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [5:0] pins_i,
   input  logic       act_i,
   input  logic [2:0] step_i,
   output joy_word_t  joy_o,
   output logic       six_o,
   output logic       md_o
);

   logic [5:0]  meta_q, pin_q;
   joy_word_t   shadow_q, shadow_d;
   logic        md_q, md_d, six_q, six_d;
   joy_status_t raw, pub_q, pub_d;
`ifdef DB9_JOY_DEBOUNCE_EN
   joy_status_t prev_q, prev_d;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      shadow_d = shadow_q;
      md_d     = md_q;
      six_d    = six_q;
      pub_d    = pub_q;
      raw      = '{six: six_q, md: md_q, word: ~shadow_q};
`ifdef DB9_JOY_DEBOUNCE_EN
      prev_d   = prev_q;
`endif
      if (act_i) begin
         case (step_i)
            STEP_SAMPLE_HI: begin
               shadow_d[JOY_R:JOY_U] = pin_q[PIN_R:PIN_U];
               shadow_d[JOY_C:JOY_B] = pin_q[PIN_P9:PIN_P6];
               six_d                 = 1'b0;
            end
            STEP_SAMPLE_LO: begin
               // Both horizontals low while select is low only happens on a Mega Drive pad
               if (!pin_q[PIN_R] && !pin_q[PIN_L]) begin
                  md_d                  = 1'b1;
                  shadow_d[JOY_S:JOY_A] = pin_q[PIN_P9:PIN_P6];
               end else begin
                  md_d                  = 1'b0;
                  shadow_d[JOY_S:JOY_B] = {2'b11, pin_q[PIN_P9:PIN_P6]};
               end
            end
            STEP_DETECT6: begin
               if (md_q && (pin_q[PIN_R:PIN_U] == 4'b0000)) six_d = 1'b1;
            end
            STEP_SAMPLE_EXT: begin
               shadow_d[JOY_M:JOY_Z] = six_q ? pin_q[PIN_R:PIN_U] : 4'b1111;
            end
            STEP_PUB: begin
`ifdef DB9_JOY_DEBOUNCE_EN
               if (raw == prev_q) pub_d = raw;
               prev_d = raw;
`else
               pub_d = raw;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         meta_q   <= '1;
         pin_q    <= '1;
         shadow_q <= '1;
         md_q     <= 1'b0;
         six_q    <= 1'b0;
         pub_q    <= '0;
`ifdef DB9_JOY_DEBOUNCE_EN
         prev_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         meta_q   <= pins_i;
         pin_q    <= meta_q;
         shadow_q <= shadow_d;
         md_q     <= md_d;
         six_q    <= six_d;
         pub_q    <= pub_d;
`ifdef DB9_JOY_DEBOUNCE_EN
         prev_q   <= prev_d;
`endif
      end
   end

   assign joy_o = pub_q.word;
   assign six_o = pub_q.six;
   assign md_o  = pub_q.md;

endmodule

// File: rtl/db9_joy_reader.sv
// Multi-port DB9 joystick reader: step prescaler, frame step counter and the
// shared select line; per-port sampling lives in db9_joy_port.
// Optional build macro: DB9_JOY_DEBOUNCE_EN (2-frame agreement before publish).
module db9_joy_reader
   import db9_joy_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int STEP_DIV    = 3072,
   parameter int FRAME_STEPS = 256
) (
   input  logic           clk_sys,
   input  logic           reset,
   db9_joy_reader_if.slave bus
);

   localparam int PRE_W  = $clog2(STEP_DIV);
   localparam int STEP_W = $clog2(FRAME_STEPS);

   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              select_q, select_d;
   logic              frame_done_q, frame_done_d;
   logic              tick, in_seq, step_act;
   logic [2:0]        seq_step;

   joy_word_t [NUM_PORTS-1:0] port_joy;
   logic      [NUM_PORTS-1:0] port_six;
   logic      [NUM_PORTS-1:0] port_md;

   assign tick     = (presc_q == PRE_W'(STEP_DIV - 1));
   assign in_seq   = (32'(step_q) < 32'(SEQ_STEPS));
   assign seq_step = step_q[2:0];
   assign step_act = tick && in_seq;

   always_comb begin
      presc_d      = tick ? '0 : presc_q + PRE_W'(1);
      step_d       = step_q;
      select_d     = select_q;
      frame_done_d = 1'b0;
      if (tick) begin
         step_d       = (step_q == STEP_W'(FRAME_STEPS - 1)) ? '0 : step_q + STEP_W'(1);
         // Idle steps past the sequence park select high
         select_d     = in_seq ? seq_select(seq_step) : 1'b1;
         frame_done_d = in_seq && (seq_step == STEP_PUB);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         presc_q      <= '0;
         step_q       <= '0;
         select_q     <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         step_q       <= step_d;
         select_q     <= select_d;
         frame_done_q <= frame_done_d;
      end
   end

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      db9_joy_port u_port (
         .clk_sys (clk_sys),
         .reset   (reset),
         .pins_i  (bus.joy_pins_i[k*6 +: 6]),
         .act_i   (step_act),
         .step_i  (seq_step),
         .joy_o   (port_joy[k]),
         .six_o   (port_six[k]),
         .md_o    (port_md[k])
      );
   end

   assign bus.select_o     = select_q;
   assign bus.frame_done_o = frame_done_q;
   assign bus.joy_o        = port_joy;
   assign bus.six_button_o = port_six;
   assign bus.md_pad_o     = port_md;

endmodule
